// File: rtl/bf_reduce_ctrl.sv
// rtl/bf_reduce_ctrl.sv - bf16 vector reduction sequencer around one shared combinational adder
// Streams LEN words from a synchronous-read buffer and accumulates them strictly in address order.

module BF_adder #(
    parameter int BIAS = 127
) (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    localparam logic signed [10:0] L_BIAS = 11'(BIAS);
    localparam logic signed [10:0] L_EMAX = 11'(254 - BIAS);
    localparam logic signed [10:0] L_EMIN = 11'(1 - BIAS);

    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic               w_swap;
    logic [15:0]        w_big, w_sml;
    logic [7:0]         w_diff;
    logic [4:0]         w_dcap;
    logic [10:0]        w_mbig, w_msml, w_align;
    logic [21:0]        w_sh;
    logic [11:0]        w_sum;
    logic [3:0]         w_lz;
    logic [10:0]        w_norm;
    logic signed [10:0] w_exp, w_exp_r;
    logic               w_up;
    logic [8:0]         w_rnd;
    logic [6:0]         w_frac;

    assign w_a_nan = (&i_a[14:7]) && (|i_a[6:0]);
    assign w_b_nan = (&i_b[14:7]) && (|i_b[6:0]);
    assign w_a_inf = (&i_a[14:7]) && !(|i_a[6:0]);
    assign w_b_inf = (&i_b[14:7]) && !(|i_b[6:0]);

    assign w_swap  = i_b[14:0] > i_a[14:0];
    assign w_big   = w_swap ? i_b : i_a;
    assign w_sml   = w_swap ? i_a : i_b;
    assign w_diff  = w_big[14:7] - w_sml[14:7];
    assign w_dcap  = (w_diff > 8'd21) ? 5'd21 : w_diff[4:0];
    assign w_mbig  = {1'b1, w_big[6:0], 3'b000};
    assign w_msml  = {1'b1, w_sml[6:0], 3'b000};
    // Three guard positions plus a sticky bit folded into the LSB give round-to-nearest-even.
    assign w_sh    = {w_msml, 11'd0} >> w_dcap;
    assign w_align = {w_sh[21:12], w_sh[11] | (|w_sh[10:0])};
    assign w_sum   = (w_big[15] == w_sml[15]) ? ({1'b0, w_mbig} + {1'b0, w_align})
                                              : ({1'b0, w_mbig} - {1'b0, w_align});

    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (w_sum[i]) w_lz = 4'(10 - i);
        end
        if (w_sum[11]) begin
            w_norm = {w_sum[11:2], w_sum[1] | w_sum[0]};
            w_exp  = $signed({3'b000, w_big[14:7]}) - L_BIAS + 11'sd1;
        end else begin
            w_norm = w_sum[10:0] << w_lz;
            w_exp  = $signed({3'b000, w_big[14:7]}) - L_BIAS - $signed({7'd0, w_lz});
        end
        w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd   = {1'b0, w_norm[10:3]} + {8'd0, w_up};
        w_exp_r = w_rnd[8] ? (w_exp + 11'sd1) : w_exp;
        w_frac  = w_rnd[8] ? w_rnd[7:1] : w_rnd[6:0];
    end

    always_comb begin
        o_sum = 16'h7FC0;
        if (w_a_nan || w_b_nan) begin
            o_sum = 16'h7FC0;
        end else if (w_a_inf && w_b_inf && (i_a[15] != i_b[15])) begin
            o_sum = 16'h7FC0;
        end else if (w_a_inf) begin
            o_sum = i_a;
        end else if (w_b_inf) begin
            o_sum = i_b;
        end else if (w_big[14:7] == 8'd0) begin
            o_sum = {i_a[15] & i_b[15], 15'd0};
        end else if (w_sml[14:7] == 8'd0) begin
            o_sum = w_big;
        end else if (w_sum == 12'd0) begin
            o_sum = 16'h0000;
        end else if (w_exp_r > L_EMAX) begin
            o_sum = {w_big[15], 8'hFF, 7'd0};
        end else if (w_exp_r < L_EMIN) begin
            o_sum = {w_big[15], 15'd0};
        end else begin
            o_sum = {w_big[15], 8'(w_exp_r + L_BIAS), w_frac};
        end
    end
endmodule

module bf_reduce_ctrl #(
    parameter int BIAS       = 127,
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [ADDR_WIDTH:0] L_MAXLEN = (ADDR_WIDTH+1)'(ARRAY_SIZE);

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  r_vld, r_first;
    logic [DATA_WIDTH-1:0] r_acc, r_result;
    logic [ADDR_WIDTH:0]   w_len_c, w_len_m1;
    logic                  w_accept, w_last;
    logic [DATA_WIDTH-1:0] w_sum, w_acc_next;

    BF_adder #(.BIAS(BIAS)) u_add (
        .i_a   (r_acc),
        .i_b   (rd_data),
        .o_sum (w_sum)
    );

    assign w_len_c    = (len > L_MAXLEN) ? L_MAXLEN : len;
    assign w_len_m1   = r_len - (ADDR_WIDTH+1)'(1);
    assign w_last     = ({1'b0, r_addr} == w_len_m1);
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_FIN));
    // The first datum seeds the accumulator verbatim so -0, NaN payloads and denormals survive.
    assign w_acc_next = r_first ? rd_data : w_sum;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_FIN: begin
                w_state_next = S_IDLE;
                if (start) w_state_next = (w_len_c != '0) ? S_RUN : S_FIN;
            end
            S_RUN:   if (w_last) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_FIN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_vld    <= 1'b0;
            r_first  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            r_vld   <= (r_state == S_RUN);
            if (r_vld) begin
                r_acc   <= w_acc_next;
                r_first <= 1'b0;
            end
            if (w_accept) begin
                r_len   <= w_len_c;
                r_addr  <= '0;
                r_first <= 1'b1;
                r_acc   <= '0;
            end else if ((r_state == S_RUN) && !w_last) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (r_state == S_DRAIN) begin
                r_result <= w_acc_next;
            end else if (w_accept && (w_len_c == '0)) begin
                r_result <= '0;
            end
        end
    end

    assign rd_en   = (r_state == S_RUN);
    assign rd_addr = r_addr;
    assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done    = (r_state == S_FIN);
    assign result  = r_result;
endmodule

// File: tb/tb_bf_reduce_ctrl.sv
// tb/tb_bf_reduce_ctrl.sv - directed vector bench for bf_reduce_ctrl
module tb_bf_reduce_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;

    logic [15:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  n;
        logic [15:0] d0, d1, d2, d3;
        logic [15:0] e;
    } vec_t;
    vec_t vecs[$];

    bf_reduce_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic run_vec(input logic [7:0] n, output int lat, output int nrd,
                           output logic addr_ok, output logic busy_ok, output logic [15:0] res);
        start = 1'b1;
        len   = n;
        step();
        start   = 1'b0;
        lat     = 1;
        nrd     = 0;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        while (!done && lat < 400) begin
            if (busy !== (n != 8'd0)) busy_ok = 1'b0;
            if (rd_en) begin
                if (rd_addr !== 7'(nrd)) addr_ok = 1'b0;
                nrd++;
            end
            step();
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        if (rd_en) nrd++;
        res = result;
        step();
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 128; i++) mem[i] = v;
    endtask

    initial begin
        int lat, nrd, elen, c, ndone;
        logic aok, bok;
        logic [15:0] res;

        vecs.push_back('{8'd4, 16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h4120});
        vecs.push_back('{8'd1, 16'hC0A0, 16'h0000, 16'h0000, 16'h0000, 16'hC0A0});
        vecs.push_back('{8'd0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0000});
        vecs.push_back('{8'd1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000});
        vecs.push_back('{8'd1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001});
        vecs.push_back('{8'd1, 16'h7FC1, 16'h0000, 16'h0000, 16'h0000, 16'h7FC1});
        vecs.push_back('{8'd2, 16'h3F80, 16'h3B80, 16'h0000, 16'h0000, 16'h3F80});
        vecs.push_back('{8'd2, 16'h3F81, 16'h3B80, 16'h0000, 16'h0000, 16'h3F82});
        vecs.push_back('{8'd2, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'h0000});
        vecs.push_back('{8'd2, 16'h3F80, 16'hC040, 16'h0000, 16'h0000, 16'hC000});
        vecs.push_back('{8'd2, 16'h3FC0, 16'h4010, 16'h0000, 16'h0000, 16'h4070});
        vecs.push_back('{8'd2, 16'hBFC0, 16'h3E80, 16'h0000, 16'h0000, 16'hBFA0});
        vecs.push_back('{8'd2, 16'h7FC0, 16'h3F80, 16'h0000, 16'h0000, 16'h7FC0});
        vecs.push_back('{8'd3, 16'h7F80, 16'h3F80, 16'h4000, 16'h0000, 16'h7F80});
        vecs.push_back('{8'd2, 16'h7F80, 16'hFF80, 16'h0000, 16'h0000, 16'h7FC0});
        vecs.push_back('{8'd2, 16'h7F7F, 16'h7F7F, 16'h0000, 16'h0000, 16'h7F80});
        vecs.push_back('{8'd2, 16'h4B00, 16'h3F80, 16'h0000, 16'h0000, 16'h4B00});
        vecs.push_back('{8'd3, 16'h3F80, 16'h3B80, 16'h3B80, 16'h0000, 16'h3F80});
        vecs.push_back('{8'd3, 16'h3B80, 16'h3B80, 16'h3F80, 16'h0000, 16'h3F81});

        fill(16'h0000);
        rst = 1'b1;
        repeat (3) step();
        chk("reset rd_en", {31'd0, rd_en}, 32'd0);
        chk("reset rd_addr", {25'd0, rd_addr}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", {16'd0, result}, 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            mem[0] = vecs[i].d0; mem[1] = vecs[i].d1;
            mem[2] = vecs[i].d2; mem[3] = vecs[i].d3;
            run_vec(vecs[i].n, lat, nrd, aok, bok, res);
            elen = int'(vecs[i].n);
            chk($sformatf("vec%0d result", i), {16'd0, res}, {16'd0, vecs[i].e});
            chk($sformatf("vec%0d done latency", i), 32'(lat), (elen == 0) ? 32'd1 : 32'(elen + 2));
            chk($sformatf("vec%0d read count", i), 32'(nrd), 32'(elen));
            chk($sformatf("vec%0d addr seq", i), {31'd0, aok}, 32'd1);
            chk($sformatf("vec%0d busy", i), {31'd0, bok}, 32'd1);
        end

        // Full-length run, then an over-length request that must clamp to the buffer depth.
        fill(16'h3F80);
        for (int k = 0; k < 2; k++) begin
            run_vec((k == 0) ? 8'd128 : 8'd200, lat, nrd, aok, bok, res);
            chk($sformatf("len%0d result", k), {16'd0, res}, 32'h4300);
            chk($sformatf("len%0d latency", k), 32'(lat), 32'd130);
            chk($sformatf("len%0d read count", k), 32'(nrd), 32'd128);
            chk($sformatf("len%0d addr seq", k), {31'd0, aok}, 32'd1);
            chk($sformatf("len%0d addr hold", k), {25'd0, rd_addr}, 32'd127);
        end

        // Start during a run is ignored; start in FIN launches a back-to-back run.
        mem[0] = 16'h3F80; mem[1] = 16'h4000; mem[2] = 16'h4040; mem[3] = 16'h4080;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        c = 1;
        while (!done && c < 400) begin
            start = (c == 3);
            len   = (c == 3) ? 8'd1 : 8'd4;
            step();
            c++;
        end
        start = 1'b0;
        chk("ignored start done cycle", 32'(c), 32'd6);
        chk("ignored start result", {16'd0, result}, 32'h4120);
        mem[0] = 16'h4000; mem[1] = 16'h4000;
        run_vec(8'd2, lat, nrd, aok, bok, res);
        chk("fin start latency", 32'(lat), 32'd4);
        chk("fin start result", {16'd0, res}, 32'h4080);
        chk("fin start reads", 32'(nrd), 32'd2);

        // Reset mid-run clears outputs at once and suppresses the pending done.
        mem[0] = 16'h3F80; mem[1] = 16'h4000; mem[2] = 16'h4040; mem[3] = 16'h4080;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst rd_addr", {25'd0, rd_addr}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", {16'd0, result}, 32'd0);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy || rd_en) ndone++;
            step();
        end
        chk("post-rst quiet", 32'(ndone), 32'd0);
        run_vec(8'd4, lat, nrd, aok, bok, res);
        chk("post-rst result", {16'd0, res}, 32'h4120);
        chk("post-rst latency", 32'(lat), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
